// File: rtl/sdr_init_pkg.sv
// Shared types for the SDRAM init/refresh scheduler: FSM states, init step codes,
// rank-width helper and the per-rank SDR/DDR step tables.
package sdr_init_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_WAIT,
    ST_INIT,
    ST_HOLD,
    ST_RUN
  } state_e;

  typedef enum logic [2:0] {
    STEP_NONE,
    STEP_PRE,
    STEP_EMR,
    STEP_MRS_DLL,
    STEP_MRS,
    STEP_RF
  } step_e;

  localparam logic [2:0] SDR_LAST_STEP = 3'd2;
  localparam logic [2:0] DDR_LAST_STEP = 3'd6;

  function automatic int rank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // DDR per-rank order: PRE, EMR, MRS(DLL reset), PRE, RF, RF, MRS
  function automatic step_e ddr_step(input logic [2:0] idx);
    case (idx)
      3'd0:    return STEP_PRE;
      3'd1:    return STEP_EMR;
      3'd2:    return STEP_MRS_DLL;
      3'd3:    return STEP_PRE;
      3'd4:    return STEP_RF;
      3'd5:    return STEP_RF;
      default: return STEP_MRS;
    endcase
  endfunction

  // SDR index 1 is repeated INIT_REFRESHES times by the sequencer
  function automatic step_e sdr_step(input logic [2:0] idx);
    case (idx)
      3'd0:    return STEP_PRE;
      3'd1:    return STEP_RF;
      default: return STEP_MRS;
    endcase
  endfunction

endpackage

// File: rtl/sdr_init_refresh_sched_if.sv
// Request/acknowledge bundle between the init/refresh scheduler (master) and the
// SDRAM command engine (slave); requests are levels held until S_ACK.
interface sdr_init_refresh_sched_if #(
  parameter int RANK_W = 1
);
  logic              P_REQ;
  logic              RF_REQ;
  logic              M_REQ;
  logic              EM_REQ;
  logic              M_REQ_DLL_RESET;
  logic [RANK_W-1:0] REQ_RANK;
  logic              S_ACK;
  logic              IDLE;

  modport master (
    output P_REQ, RF_REQ, M_REQ, EM_REQ, M_REQ_DLL_RESET, REQ_RANK,
    input  S_ACK, IDLE
  );

  modport slave (
    input  P_REQ, RF_REQ, M_REQ, EM_REQ, M_REQ_DLL_RESET, REQ_RANK,
    output S_ACK, IDLE
  );
endinterface

// File: rtl/sdr_refresh_timer.sv
// Loadable down-counter shared by power-up wait, DLL holdoff and refresh interval.
// Load wins over decrement; the count parks at zero.
module sdr_refresh_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               CLK,
  input  logic               aresetn,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] val_i,
  input  logic               dec_i,
  output logic               zero_o,
  output logic               one_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == TIMER_W'(1));

endmodule

// File: rtl/sdr_init_refresh_sched.sv
// SDRAM init sequencer + round-robin refresh scheduler; requests are registered levels held until S_ACK.
// Build option SDR_REFRESH_DEBT_EN: refresh debt counter with IDLE-gated issue (else 1-deep pending).
module sdr_init_refresh_sched
  import sdr_init_pkg::*;
#(
  parameter int NUM_RANKS      = 1,
  parameter int INIT_REFRESHES = 8,
  parameter int TIMER_W        = 16,
  parameter int HOLDOFF_CYCLES = 200,
  parameter int DEBT_MAX       = 8
) (
  input  logic                     CLK,
  input  logic                     aresetn,
  input  logic                     SD_INIT,
  input  logic                     DDR_MODE,
  input  logic [TIMER_W-1:0]       DELAY,
  input  logic [TIMER_W-1:0]       REF,
  sdr_init_refresh_sched_if.master cmd,
  output logic                     INITED,
  output logic                     DQM_INIT,
  output logic                     REF_OVERRUN
);

  localparam int RANK_W = rank_w(NUM_RANKS);
`ifdef SDR_REFRESH_DEBT_EN
  localparam int PEND_MAX = DEBT_MAX;
`else
  localparam int PEND_MAX = 1;
  localparam int DEBT_MAX_UNUSED = DEBT_MAX;
`endif
  localparam int PEND_W = $clog2(PEND_MAX + 1);

  state_e              state_q, state_d;
  step_e               req_q, req_d;
  logic [RANK_W-1:0]   rank_q, rank_d;
  logic [2:0]          step_q, step_d;
  logic [3:0]          rf_cnt_q, rf_cnt_d;
  logic                ddr_q, ddr_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                ovr_q, ovr_d;
  logic                dqm_q, dqm_d;

  logic                tmr_load, tmr_dec, tmr_zero, tmr_one;
  logic [TIMER_W-1:0]  tmr_val;
  logic                ack, rf_ack, tick, rf_want, last_rank, pend_full;
  step_e               cur_step;
  logic [2:0]          last_step;
  logic [RANK_W-1:0]   rank_inc;

  sdr_refresh_timer #(.TIMER_W(TIMER_W)) u_timer (
    .CLK    (CLK),
    .aresetn(aresetn),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .dec_i  (tmr_dec),
    .zero_o (tmr_zero),
    .one_o  (tmr_one)
  );

  assign ack       = (req_q != STEP_NONE) && cmd.S_ACK;
  assign rf_ack    = ack && (req_q == STEP_RF);
  assign tick      = (state_q == ST_RUN) && tmr_one && (REF != '0);
  assign cur_step  = ddr_q ? ddr_step(step_q) : sdr_step(step_q);
  assign last_step = ddr_q ? DDR_LAST_STEP : SDR_LAST_STEP;
  assign last_rank = (rank_q == RANK_W'(NUM_RANKS - 1));
  assign rank_inc  = last_rank ? '0 : rank_q + 1'b1;
  assign pend_full = (pend_q == PEND_W'(PEND_MAX));

`ifdef SDR_REFRESH_DEBT_EN
  assign rf_want = (cmd.IDLE && (pend_q != '0)) || pend_full;
`else
  logic idle_unused;
  assign idle_unused = cmd.IDLE;
  assign rf_want     = (pend_q != '0);
`endif

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    rank_d   = rank_q;
    step_d   = step_q;
    rf_cnt_d = rf_cnt_q;
    ddr_d    = ddr_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    dqm_d    = !((state_q == ST_RUN) || (state_q == ST_HOLD));
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;

    // A simultaneous tick and refresh ack cancel out
    if (tick && !rf_ack) begin
      if (pend_full) ovr_d = 1'b1;
      else           pend_d = pend_q + 1'b1;
    end else if (rf_ack && !tick) begin
      pend_d = pend_q - 1'b1;
    end

    case (state_q)
      ST_LOAD: begin
        tmr_load = 1'b1;
        tmr_val  = DELAY;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (tmr_zero) begin
          state_d  = ST_INIT;
          ddr_d    = DDR_MODE;
          step_d   = '0;
          rf_cnt_d = '0;
          rank_d   = '0;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_INIT: begin
        if (req_q == STEP_NONE) begin
          req_d = cur_step;
        end else if (ack) begin
          req_d = STEP_NONE;
          if (!ddr_q && (step_q == 3'd1) && (rf_cnt_q != 4'(INIT_REFRESHES - 1))) begin
            rf_cnt_d = rf_cnt_q + 1'b1;
          end else if (step_q != last_step) begin
            step_d   = step_q + 1'b1;
            rf_cnt_d = '0;
          end else begin
            step_d   = '0;
            rf_cnt_d = '0;
            rank_d   = rank_inc;
            if (last_rank) begin
              tmr_load = 1'b1;
              if (ddr_q && (HOLDOFF_CYCLES != 0)) begin
                state_d = ST_HOLD;
                tmr_val = TIMER_W'(HOLDOFF_CYCLES);
              end else begin
                state_d = ST_RUN;
                tmr_val = REF;
              end
            end
          end
        end
      end
      ST_HOLD: begin
        if (tmr_zero || tmr_one) begin
          state_d  = ST_RUN;
          tmr_load = 1'b1;
          tmr_val  = REF;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_RUN: begin
        if (tmr_zero || tmr_one) begin
          tmr_load = 1'b1;
          tmr_val  = REF;
        end else begin
          tmr_dec = 1'b1;
        end
        if (req_q == STEP_NONE) begin
          if (rf_want) req_d = STEP_RF;
        end else if (ack) begin
          req_d  = STEP_NONE;
          rank_d = rank_inc;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // Restart abandons any in-flight handshake
    if (SD_INIT) begin
      state_d  = ST_LOAD;
      req_d    = STEP_NONE;
      rank_d   = '0;
      step_d   = '0;
      rf_cnt_d = '0;
      pend_d   = '0;
      ovr_d    = 1'b0;
      dqm_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_LOAD;
      req_q    <= STEP_NONE;
      rank_q   <= '0;
      step_q   <= '0;
      rf_cnt_q <= '0;
      ddr_q    <= 1'b0;
      pend_q   <= '0;
      ovr_q    <= 1'b0;
      dqm_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      rank_q   <= rank_d;
      step_q   <= step_d;
      rf_cnt_q <= rf_cnt_d;
      ddr_q    <= ddr_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      dqm_q    <= dqm_d;
    end
  end

  assign cmd.P_REQ           = (req_q == STEP_PRE);
  assign cmd.EM_REQ          = (req_q == STEP_EMR);
  assign cmd.M_REQ           = (req_q == STEP_MRS) || (req_q == STEP_MRS_DLL);
  assign cmd.M_REQ_DLL_RESET = (req_q == STEP_MRS_DLL);
  assign cmd.RF_REQ          = (req_q == STEP_RF);
  assign cmd.REQ_RANK        = rank_q;
  assign INITED              = (state_q == ST_RUN);
  assign DQM_INIT            = dqm_q;
  assign REF_OVERRUN         = ovr_q;

endmodule
